conv_encoder: RTL and testbench

- Rate-1/2, constraint-length-3 convolutional encoder (generators 7,5 octal). It is the transmit-side counterpart of the Viterbi decoder front end, and produces the bit_pair stream that the BMU chain consumes.
- Accepts one information bit per handshake for a fixed-length frame. Appends K-1=2 zero tail bits so the trellis terminates in state 00.
- Emits one registered 2-bit code pair per bit, with valid/ready backpressure on both sides.

---
 rtl/conv_encoder.sv | 152 +++++++++++++++
 tb/tb_conv_encoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder (generators 7,5 octal).
// Takes FRAME_LEN information bits per frame over a valid/ready input,
// appends two zero tail bits so the trellis ends in state 00, and emits
// one registered code pair per bit over a valid/ready output.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high; a valid producer holds its payload
// stable until that edge, and ready may depend combinationally on state.
module conv_encoder #(
    parameter int FRAME_LEN = 8,  // information bits per frame, 1..255
    parameter int CNT_W     = 8   // bit counter width, 2**CNT_W > FRAME_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       refresh,
    input  logic       start,
    input  logic       data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [1:0] bit_pair_out,
    output logic       pair_valid,
    input  logic       pair_ready,
    output logic       busy,
    output logic       frame_done,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENCODE = 2'd1,
        S_FLUSH  = 2'd2,
        S_DRAIN  = 2'd3
    } state_e;

    // Count value at which the last information bit / last tail bit loads.
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(1);

    state_e           state_q;
    logic             s1_q;          // previous bit
    logic             s2_q;          // bit before the previous one
    logic [CNT_W-1:0] count_q;
    logic [1:0]       pair_q;
    logic             pair_valid_q;
    logic             frame_done_q;

    logic             slot_free;
    logic             load_d;
    logic             u_d;
    logic [1:0]       pair_d;
    logic [CNT_W-1:0] count_d;

    // Decide whether a code pair is loaded this cycle and what it contains.
    always_comb begin
        slot_free = !pair_valid_q || pair_ready;
        load_d    = 1'b0;
        u_d       = 1'b0;
        case (state_q)
            S_ENCODE: begin
                load_d = data_valid && slot_free;
                u_d    = data_in;
            end
            S_FLUSH: begin
                load_d = slot_free;
                u_d    = 1'b0;   // tail bits are zero
            end
            default: begin
                load_d = 1'b0;
                u_d    = 1'b0;
            end
        endcase
        pair_d  = {u_d ^ s1_q ^ s2_q, u_d ^ s2_q};
        count_d = count_q + 1'b1;
    end

    // Frame sequencing, shift register, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            count_q      <= '0;
            pair_q       <= 2'b00;
            pair_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (refresh) begin
            state_q      <= S_IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            count_q      <= '0;
            pair_q       <= 2'b00;
            pair_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            // A consumed pair empties the slot unless a load refills it below.
            if (pair_valid_q && pair_ready) begin
                pair_valid_q <= 1'b0;
            end

            if (load_d) begin
                pair_q       <= pair_d;
                pair_valid_q <= 1'b1;
                s2_q         <= s1_q;
                s1_q         <= u_d;
                count_q      <= count_d;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ENCODE;
                        count_q <= '0;
                        s1_q    <= 1'b0;
                        s2_q    <= 1'b0;
                    end
                end
                S_ENCODE: begin
                    if (load_d && (count_q == LAST_BIT)) begin
                        state_q <= S_FLUSH;
                        count_q <= '0;
                    end
                end
                S_FLUSH: begin
                    // Second tail load leaves the shift register at 00.
                    if (load_d && (count_q == TAIL_LAST)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Frame ends once the final tail pair is taken downstream.
                    if (pair_valid_q && pair_ready) begin
                        frame_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign data_ready   = (state_q == S_ENCODE) && slot_free;
    assign bit_pair_out = pair_q;
    assign pair_valid   = pair_valid_q;
    assign busy         = (state_q != S_IDLE);
    assign frame_done   = frame_done_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: a FRAME_LEN=4 instance driven
// through handshake tasks with a queue scoreboard, plus a FRAME_LEN=8
// instance for the all-zero frame and frame_done timing.
module tb_conv_encoder;

    localparam int FL = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // FRAME_LEN=4 instance signals
    logic       refresh = 1'b0;
    logic       start = 1'b0;
    logic       data_in = 1'b0;
    logic       data_valid = 1'b0;
    logic       pair_ready = 1'b0;
    logic       data_ready;
    logic [1:0] bit_pair_out;
    logic       pair_valid;
    logic       busy;
    logic       frame_done;
    logic [1:0] state_dbg;

    // FRAME_LEN=8 instance signals
    logic       z_refresh = 1'b0;
    logic       z_start = 1'b0;
    logic       z_data_in = 1'b0;
    logic       z_data_valid = 1'b1;
    logic       z_pair_ready = 1'b1;
    logic       z_data_ready;
    logic [1:0] z_pair;
    logic       z_pv;
    logic       z_busy;
    logic       z_done;
    logic [1:0] z_dbg;

    conv_encoder #(.FRAME_LEN(FL), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .refresh(refresh), .start(start),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .bit_pair_out(bit_pair_out), .pair_valid(pair_valid),
        .pair_ready(pair_ready), .busy(busy), .frame_done(frame_done),
        .state_dbg(state_dbg)
    );

    conv_encoder #(.FRAME_LEN(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .refresh(z_refresh), .start(z_start),
        .data_in(z_data_in), .data_valid(z_data_valid), .data_ready(z_data_ready),
        .bit_pair_out(z_pair), .pair_valid(z_pv),
        .pair_ready(z_pair_ready), .busy(z_busy), .frame_done(z_done),
        .state_dbg(z_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [1:0] exp_q[$];
    logic [1:0] rx_log[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         ready_mode = 0;  // 0: always ready, 1: toggle, 2: random
    logic       m_s1 = 1'b0;
    logic       m_s2 = 1'b0;
    logic       prev_stalled = 1'b0;
    logic [1:0] prev_pair = 2'b00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder: one expected pair per accepted bit.
    task automatic model_push(input logic u);
        exp_q.push_back({u ^ m_s1 ^ m_s2, u ^ m_s2});
        m_s2 = m_s1;
        m_s1 = u;
    endtask

    // Downstream ready pattern generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       pair_ready = 1'b1;
                1:       pair_ready = ~pair_ready;
                default: pair_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: compares every handshaken pair and checks stall holding.
    always @(negedge clk) begin
        if (!rst_n || refresh) begin
            prev_stalled = 1'b0;
        end else begin
            if (prev_stalled) begin
                check_eq("stall_valid", 32'(pair_valid), 32'd1);
                check_eq("stall_hold", 32'(bit_pair_out), 32'(prev_pair));
            end
            if (pair_valid && pair_ready) begin
                rx_log.push_back(bit_pair_out);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pair_extra: got %b expected none", bit_pair_out);
                end else begin
                    check_eq("pair", 32'(bit_pair_out), 32'(exp_q.pop_front()));
                end
            end
            prev_stalled = pair_valid && !pair_ready;
            prev_pair    = bit_pair_out;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic b);
        bit hs;
        hs = 1'b0;
        data_in    = b;
        data_valid = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = data_ready;
            if (hs) model_push(b);
            @(posedge clk);
            #1;
        end
        data_valid = 1'b0;
        check_eq("bit_accepted", 32'(hs), 32'd1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check_eq("done_busy", 32'(busy), 32'd0);
            check_eq("done_pv", 32'(pair_valid), 32'd0);
            check_eq("done_q_empty", 32'(exp_q.size()), 32'd0);
            @(negedge clk);
            check_eq("done_pulse_width", 32'(frame_done), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic finish_frame();
        model_push(1'b0);
        model_push(1'b0);
        wait_done();
    endtask

    task automatic run_bits(input logic [7:0] bits, input int n, input int gap, input bit do_start);
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        rx_log.delete();
        if (do_start) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            drive_bit(bits[i]);
            if (i == 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    if (g > 0 && ready_mode == 0) check_eq("gap_pv", 32'(pair_valid), 32'd0);
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    // Compare the received pairs of the last frame against a fixed sequence.
    task automatic check_log(input string tag, input logic [11:0] exp);
        check_eq({tag, "_len"}, 32'(rx_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < rx_log.size())
                check_eq($sformatf("%s_p%0d", tag, i), 32'(rx_log[i]), 32'(exp[11-2*i -: 2]));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_pair"}, 32'(bit_pair_out), 32'd0);
        check_eq({tag, "_pv"}, 32'(pair_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(frame_done), 32'd0);
        check_eq({tag, "_dready"}, 32'(data_ready), 32'd0);
        check_eq({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    // All-zero 8-bit frame on the second instance: 10 pairs of 00, then
    // frame_done exactly one cycle after the 10th handshake.
    task automatic run_zero8();
        int hs_cnt;
        int last_cyc;
        int done_cyc;
        hs_cnt   = 0;
        last_cyc = -10;
        done_cyc = -1;
        z_start = 1'b1;
        @(posedge clk);
        #1;
        z_start = 1'b0;
        for (int cyc = 0; cyc < 60 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (z_done) begin
                done_cyc = cyc;
            end else if (z_pv && z_pair_ready) begin
                check_eq("z8_pair", 32'(z_pair), 32'd0);
                hs_cnt++;
                last_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        check_eq("z8_pair_count", 32'(hs_cnt), 32'd10);
        check_eq("z8_done_latency", 32'(done_cyc), 32'(last_cyc + 1));
        check_eq("z8_busy_after", 32'(z_busy), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] rb;
        #2;
        check_idle_outputs("reset");
        check_eq("reset_z8_busy", 32'(z_busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        data_valid = 1'b1;          // must be ignored in IDLE
        @(negedge clk);
        check_eq("idle_dready", 32'(data_ready), 32'd0);
        @(posedge clk);
        #1;
        data_valid = 1'b0;

        // Basic frame, always ready: 1,0,1,1 -> 11,10,00,01,01,11
        ready_mode = 0;
        run_bits(8'b0000_1101, FL, 0, 1'b1);
        finish_frame();
        check_log("basic", 12'b11_10_00_01_01_11);

        // Downstream toggling ready
        ready_mode = 1;
        run_bits(8'b0000_1101, FL, 0, 1'b1);
        finish_frame();
        check_log("toggle", 12'b11_10_00_01_01_11);

        // Two idle cycles after the first bit
        ready_mode = 0;
        run_bits(8'b0000_1101, FL, 2, 1'b1);
        finish_frame();
        check_log("gaps", 12'b11_10_00_01_01_11);

        // All-zero 8-bit frame on the FRAME_LEN=8 instance
        run_zero8();

        // Asynchronous reset after the second bit aborts the frame
        run_bits(8'b0000_1111, 2, 0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_bits(8'b0000_1111, FL, 0, 1'b1);
        finish_frame();
        check_log("after_rst", 12'b11_01_10_10_01_11);

        // Synchronous refresh after the third bit aborts the frame
        run_bits(8'b0000_0111, 3, 0, 1'b1);
        refresh = 1'b1;
        @(posedge clk);
        #1;
        refresh = 1'b0;
        check_idle_outputs("refresh");
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_eq("refresh_no_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        run_bits(8'b0000_1001, FL, 0, 1'b1);
        finish_frame();

        // start held high: back-to-back frames, start ignored mid-frame
        start = 1'b1;
        run_bits(8'b0000_1111, FL, 0, 1'b0);
        finish_frame();
        run_bits(8'b0000_1101, FL, 0, 1'b0);
        start = 1'b0;
        finish_frame();
        check_log("held_start", 12'b11_10_00_01_01_11);

        // Random frames with random downstream ready and random gaps
        ready_mode = 2;
        for (int f = 0; f < 4; f++) begin
            rb = 8'($urandom_range(0, 255));
            run_bits(rb, FL, int'($urandom_range(0, 2)), 1'b1);
            finish_frame();
            check_eq("rand_len", 32'(rx_log.size()), 32'(FL + 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
